// File: rtl/uart_baud_sched.sv
// uart_baud_sched: shared-divisor bit-tick scheduler for a UART TX/RX pair.
//
// A single 32-bit divisor (div_q, clocks per bit) drives two independent
// phase counters. While a channel's requester holds its request level high
// the channel runs and emits a one-cycle tick every div_q clocks. The
// divisor can only be rewritten while both channels are idle; a write
// attempted while either channel is active is dropped and flagged on cfg_err.
//
// Optional feature macro: RX_HALF_BIT_ALIGN_EN
//   defined   -> RX waits in ALIGN for an rx_sync start-edge strobe, then
//                preloads its counter to floor(div_q/2) so ticks land mid-bit.
//   undefined -> RX ignores rx_sync and behaves exactly like TX.
//
// Parameters:
//   SRC_CLK  source clock frequency, Hz
//   DIV      baud rate used to derive the divisor at reset, Hz
//
// Ports:
//   src_clk  in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   div_cfg  in   requested divisor (clocks per bit)
//   cfg_wr   in   one-cycle strobe to load div_cfg
//   tx_req   in   level, TX wants bit ticks
//   rx_req   in   level, RX wants bit ticks
//   rx_sync  in   one-cycle start-edge strobe from RX
//   tx_tick  out  one-cycle bit tick to TX
//   rx_tick  out  one-cycle bit tick to RX
//   busy     out  either channel not idle
//   cfg_err  out  one-cycle pulse, cfg_wr rejected
//   div_q    out  divisor in use
module uart_baud_sched #(
  parameter int unsigned SRC_CLK = 50000000,
  parameter int unsigned DIV     = 9600
) (
  input  logic        src_clk,
  input  logic        rst,
  input  logic [31:0] div_cfg,
  input  logic        cfg_wr,
  input  logic        tx_req,
  input  logic        rx_req,
  input  logic        rx_sync,
  output logic        tx_tick,
  output logic        rx_tick,
  output logic        busy,
  output logic        cfg_err,
  output logic [31:0] div_q
);

  localparam logic [31:0] RST_DIV_RAW = 32'(SRC_CLK / DIV);
  localparam logic [31:0] RST_DIV     = (RST_DIV_RAW < 32'd2) ? 32'd2 : RST_DIV_RAW;

  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < 32'd2) ? 32'd2 : v;
  endfunction

  typedef enum logic {
    TX_IDLE,
    TX_RUN
  } tx_state_t;

`ifdef RX_HALF_BIT_ALIGN_EN
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ALIGN,
    RX_RUN
  } rx_state_t;
`else
  typedef enum logic {
    RX_IDLE,
    RX_RUN
  } rx_state_t;
`endif

  tx_state_t   tx_state, tx_next;
  rx_state_t   rx_state, rx_next;
  logic [31:0] tx_cnt, tx_cnt_next;
  logic [31:0] rx_cnt, rx_cnt_next;
  logic [31:0] div_next;
  logic        tx_tick_next, rx_tick_next;
  logic        busy_next, cfg_err_next;
  logic        both_idle;
  logic [31:0] wrap_at;

`ifndef RX_HALF_BIT_ALIGN_EN
  logic unused_rx_sync;
  always_comb unused_rx_sync = rx_sync;
`endif

  // Divisor only changes while both channels are idle, so wrap_at is stable
  // for the whole time either counter is running.
  always_comb begin
    wrap_at = div_q - 32'd1;
  end

  // Divisor write acceptance is judged on the current (pre-edge) states.
  always_comb begin
    both_idle    = (tx_state == TX_IDLE) && (rx_state == RX_IDLE);
    div_next     = div_q;
    cfg_err_next = 1'b0;
    if (cfg_wr) begin
      if (both_idle) div_next = clamp_div(div_cfg);
      else           cfg_err_next = 1'b1;
    end
  end

  // TX channel
  always_comb begin
    tx_next      = tx_state;
    tx_cnt_next  = tx_cnt;
    tx_tick_next = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_next = '0;
        if (tx_req) tx_next = TX_RUN;
      end
      TX_RUN: begin
        if (!tx_req) begin
          tx_next     = TX_IDLE;
          tx_cnt_next = '0;
        end else if (tx_cnt == wrap_at) begin
          tx_cnt_next  = '0;
          tx_tick_next = 1'b1;
        end else begin
          tx_cnt_next = tx_cnt + 32'd1;
        end
      end
      default: begin
        tx_next     = TX_IDLE;
        tx_cnt_next = '0;
      end
    endcase
  end

  // RX channel
  always_comb begin
    rx_next      = rx_state;
    rx_cnt_next  = rx_cnt;
    rx_tick_next = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_next = '0;
`ifdef RX_HALF_BIT_ALIGN_EN
        if (rx_req) rx_next = RX_ALIGN;
`else
        if (rx_req) rx_next = RX_RUN;
`endif
      end
`ifdef RX_HALF_BIT_ALIGN_EN
      RX_ALIGN: begin
        rx_cnt_next = '0;
        if (!rx_req) begin
          rx_next = RX_IDLE;
        end else if (rx_sync) begin
          // Half-bit preload places the first tick at mid-bit.
          rx_next     = RX_RUN;
          rx_cnt_next = div_q >> 1;
        end
      end
`endif
      RX_RUN: begin
        if (!rx_req) begin
          rx_next     = RX_IDLE;
          rx_cnt_next = '0;
        end else if (rx_cnt == wrap_at) begin
          rx_cnt_next  = '0;
          rx_tick_next = 1'b1;
        end else begin
          rx_cnt_next = rx_cnt + 32'd1;
        end
      end
      default: begin
        rx_next     = RX_IDLE;
        rx_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    busy_next = (tx_next != TX_IDLE) || (rx_next != RX_IDLE);
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      tx_tick  <= 1'b0;
      rx_tick  <= 1'b0;
      busy     <= 1'b0;
      cfg_err  <= 1'b0;
      div_q    <= RST_DIV;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
      tx_cnt   <= tx_cnt_next;
      rx_cnt   <= rx_cnt_next;
      tx_tick  <= tx_tick_next;
      rx_tick  <= rx_tick_next;
      busy     <= busy_next;
      cfg_err  <= cfg_err_next;
      div_q    <= div_next;
    end
  end

endmodule

// File: doc/uart_baud_sched.md
UART_BAUD_SCHED -- requirements
Module: uart_baud_sched

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SRC_CLK  50000000  source clock frequency, Hz
  DIV      9600      reset baud rate, Hz
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  src_clk  in   1   single clock; all logic on rising edge
  rst      in   1   reset, synchronous, active-high
  div_cfg  in   32  requested divisor, clocks per bit
  cfg_wr   in   1   one-cycle strobe to load div_cfg
  tx_req   in   1   level; TX requester wants bit ticks
  rx_req   in   1   level; RX requester wants bit ticks
  rx_sync  in   1   one-cycle start-edge strobe from RX
  tx_tick  out  1   one-cycle bit tick to TX
  rx_tick  out  1   one-cycle bit tick to RX
  busy     out  1   either channel not IDLE
  cfg_err  out  1   one-cycle pulse: cfg_wr rejected
  div_q    out  32  divisor in use
REQ-003 The block SHALL use one clock, src_clk; rst SHALL be synchronous and active-high.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 The block SHALL hold one shared 32-bit divisor register, div_q, and two independent 32-bit phase counters, one for TX and one for RX.
REQ-006 Divisor clamp: any divisor value below 2 SHALL be stored as 2, at reset and on cfg_wr.
REQ-007 Acceptance of cfg_wr SHALL depend on the channel states at the sampling edge:
  - both channels IDLE: div_q = clamp(div_cfg) after that edge
  - otherwise: div_q unchanged and cfg_err high for exactly the next cycle
REQ-008 TX state machine SHALL have two states, IDLE and RUN.
  - IDLE to RUN: tx_req sampled high; counter cleared to 0
  - RUN to IDLE: tx_req sampled low; counter cleared; no tick issued on that edge
REQ-009 In RUN, the counter SHALL increment each cycle. When it equals div_q-1, it SHALL wrap to 0 and tx_tick SHALL be high for the following cycle.
REQ-010 The first tx_tick SHALL be high div_q cycles after the edge at which tx_req is first sampled high. Later ticks SHALL have a period of exactly div_q cycles.
REQ-011 If cfg_wr and a request rise are sampled on the same edge with both channels IDLE, the new divisor SHALL be accepted and SHALL govern the first tick.
REQ-012 RX state machine SHALL have three states, IDLE, ALIGN and RUN (ALIGN exists only per REQ-022).
  - IDLE to ALIGN: rx_req sampled high
  - ALIGN to RUN: rx_sync sampled high; counter preloaded with floor(div_q/2)
  - any state to IDLE: rx_req sampled low
REQ-013 In RX RUN, ticking SHALL follow REQ-009 using rx_tick. The first rx_tick after rx_sync SHALL occur div_q-floor(div_q/2) cycles later (mid-bit).
REQ-014 rx_sync SHALL be ignored in IDLE and in RUN.
REQ-015 TX and RX SHALL tick independently. Simultaneous tx_tick and rx_tick SHALL be legal.
REQ-016 busy SHALL be high while either state machine is not IDLE, updated at the same edge as the state.
REQ-017 Ticks SHALL never be level-held: each tick is exactly one cycle wide, including when div_q=2.

Reset
REQ-018 While rst is sampled high:
  - both state machines go to IDLE; both counters go to 0
  - tx_tick=0, rx_tick=0, busy=0, cfg_err=0
  - div_q = clamp(SRC_CLK/DIV), integer division
REQ-019 Reset SHALL take priority over every other input, including an in-flight cfg_wr or requests that are high.
REQ-020 After rst is released with a request still high, the channel SHALL re-enter from IDLE per REQ-008 and REQ-012.

Configuration
REQ-021 Macro RX_HALF_BIT_ALIGN_EN SHALL control RX alignment.
REQ-022 With RX_HALF_BIT_ALIGN_EN defined: RX SHALL behave per REQ-012 to REQ-014, including the ALIGN state.
REQ-023 Without RX_HALF_BIT_ALIGN_EN: the ALIGN state and preload logic SHALL be absent, rx_sync SHALL be ignored, and RX SHALL behave identically to TX per REQ-008 to REQ-010.

Verification
REQ-024 The bench SHALL cover these scenarios (SRC_CLK=50000000, DIV=9600):
  - Reset: assert rst 2 cycles -> div_q=5208, tx_tick=rx_tick=busy=cfg_err=0
  - Divisor load: idle, cfg_wr with div_cfg=10, then hold tx_req -> div_q=10; tx_tick at cycles 10, 20, 30 after tx_req sampled; busy=1
  - Clamp: idle, cfg_wr with div_cfg=1 -> div_q=2; tx_tick every 2 cycles with one low cycle between ticks
  - Rejected write: div_q=10, tx_req high, cfg_wr with div_cfg=20 -> cfg_err high 1 cycle; div_q stays 10; tick period stays 10
  - RX alignment: div_q=10, rx_req high, rx_sync after 37 cycles
      - macro defined -> no rx_tick before rx_sync; first rx_tick 5 cycles after rx_sync, then every 10
      - macro undefined -> rx_tick every 10 cycles from rx_req
  - Mid-run reset: div_q=10, tx_req held high, rst for 1 cycle -> tx_tick=0 and busy=0 next cycle; div_q=5208; first tx_tick 5208 cycles after rst release
